// File: rtl/piano_pkg.sv
// Shared definitions for the piano buzzer path: note width, owner codes, scheduler states.
package piano_pkg;

    localparam int unsigned NOTE_W_DEF = 8;
    localparam int unsigned NUM_SONGS  = 3;
    localparam int unsigned OWNER_W    = 3;

    localparam logic [OWNER_W-1:0] OWNER_NONE  = 3'd0;
    localparam logic [OWNER_W-1:0] OWNER_KEY   = 3'd1;
    localparam logic [OWNER_W-1:0] OWNER_SONG0 = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock down to a one-cycle tick every TICK_DIV clocks; clr restarts the period.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: wrap at the end of a period or restart on clear.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_c = (cnt_q == CNT_MAX);

endmodule

// File: rtl/buzzer_scheduler.sv
// Arbitrates the keyboard and three song players onto one buzzer with minimum hold and gap timing.
module buzzer_scheduler
    import piano_pkg::*;
#(
    parameter int unsigned NOTE_W   = NOTE_W_DEF,
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned MIN_HOLD = 30,
    parameter int unsigned GAP_LEN  = 10
) (
    input  logic                        iClk,
    input  logic                        iReset,
    input  logic [NOTE_W-1:0]           iKey_Note,
    input  logic [NUM_SONGS-1:0]        iSong_Req,
    input  logic [NUM_SONGS*NOTE_W-1:0] iSong_Note,
    output logic [NUM_SONGS-1:0]        iSong_Ack,
    output logic [NOTE_W-1:0]           oFreq_Data,
    output logic                        oRing,
    output logic [OWNER_W-1:0]          oOwner
);

    localparam int unsigned HOLD_MAX = (MIN_HOLD > GAP_LEN) ? MIN_HOLD : GAP_LEN;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 2);
    localparam int unsigned SUM_W    = HOLD_W + 1;

    sched_state_e           state_q, state_d;
    logic [NOTE_W-1:0]      freq_q, freq_d;
    logic                   ring_q, ring_d;
    logic [OWNER_W-1:0]     owner_q, owner_d;
    logic [NUM_SONGS-1:0]   ack_q, ack_d;
    logic [1:0]             rr_q, rr_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;

    logic                   tick_c;
    logic                   clr_c;
    logic                   leave_c;
    logic [SUM_W-1:0]       hold_sum_c;
    logic                   min_done_c;
    logic                   gap_done_c;
    logic                   key_act_c;
    logic                   grant_c;
    logic [1:0]             grant_idx_c;
    logic [1:0]             first_c;
    logic [1:0]             second_c;
    logic [NOTE_W-1:0]      song_note_c;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (iClk),
        .rst    (iReset),
        .clr    (clr_c),
        .tick_c (tick_c)
    );

    // Elapsed-tick view that counts the tick landing this cycle, so phase exits are exact.
    always_comb begin
        hold_sum_c = {1'b0, hold_q} + SUM_W'(tick_c);
        min_done_c = (hold_sum_c >= SUM_W'(MIN_HOLD));
        gap_done_c = (hold_sum_c >= SUM_W'(GAP_LEN));
        key_act_c  = (iKey_Note != '0);
    end

    // Round-robin song pick, starting one past the last granted song.
    always_comb begin
        first_c  = 2'd0;
        second_c = 2'd1;
        case (rr_q)
            2'd0:    begin first_c = 2'd1; second_c = 2'd2; end
            2'd1:    begin first_c = 2'd2; second_c = 2'd0; end
            default: begin first_c = 2'd0; second_c = 2'd1; end
        endcase
        grant_c     = 1'b1;
        grant_idx_c = rr_q;
        if (iSong_Req[first_c]) begin
            grant_idx_c = first_c;
        end else if (iSong_Req[second_c]) begin
            grant_idx_c = second_c;
        end else if (iSong_Req[rr_q]) begin
            grant_idx_c = rr_q;
        end else begin
            grant_c = 1'b0;
        end
        song_note_c = iSong_Note[32'(grant_idx_c) * NOTE_W +: NOTE_W];
    end

    // Next-state and output decode.
    always_comb begin
        state_d = state_q;
        freq_d  = freq_q;
        ring_d  = ring_q;
        owner_d = owner_q;
        ack_d   = '0;
        rr_d    = rr_q;
        hold_d  = hold_q;
        clr_c   = 1'b0;
        leave_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ring_d  = 1'b0;
                owner_d = OWNER_NONE;
                freq_d  = '0;
                if (key_act_c) begin
                    state_d = ST_PLAY;
                    freq_d  = iKey_Note;
                    ring_d  = 1'b1;
                    owner_d = OWNER_KEY;
                    hold_d  = '0;
                    clr_c   = 1'b1;
                end else if (grant_c) begin
                    state_d            = ST_PLAY;
                    ack_d[grant_idx_c] = 1'b1;
                    rr_d               = grant_idx_c;
                    freq_d             = song_note_c;
                    ring_d             = (song_note_c != '0);
                    owner_d            = OWNER_SONG0 + OWNER_W'(grant_idx_c);
                    hold_d             = '0;
                    clr_c              = 1'b1;
                end
            end

            ST_PLAY: begin
                if (tick_c && (hold_q < HOLD_W'(MIN_HOLD))) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
                if (min_done_c) begin
                    if (owner_q == OWNER_KEY) begin
                        leave_c = (iKey_Note != freq_q);
                    end else begin
                        leave_c = key_act_c || (iSong_Req != '0);
                    end
                end
                if (leave_c) begin
                    state_d = ST_GAP;
                    ring_d  = 1'b0;
                    hold_d  = '0;
                    clr_c   = 1'b1;
                end
            end

            ST_GAP: begin
                ring_d = 1'b0;
                if (tick_c) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
                if (gap_done_c) begin
                    state_d = ST_IDLE;
                    owner_d = OWNER_NONE;
                    freq_d  = '0;
                    hold_d  = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                ring_d  = 1'b0;
                owner_d = OWNER_NONE;
                freq_d  = '0;
                hold_d  = '0;
            end
        endcase
    end

    // State and output registers; round-robin pointer resets to song2 so song0 is searched first.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q <= ST_IDLE;
            freq_q  <= '0;
            ring_q  <= 1'b0;
            owner_q <= OWNER_NONE;
            ack_q   <= '0;
            rr_q    <= 2'd2;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            freq_q  <= freq_d;
            ring_q  <= ring_d;
            owner_q <= owner_d;
            ack_q   <= ack_d;
            rr_q    <= rr_d;
            hold_q  <= hold_d;
        end
    end

    assign iSong_Ack  = ack_q;
    assign oFreq_Data = freq_q;
    assign oRing      = ring_q;
    assign oOwner     = owner_q;

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Self-checking bench for buzzer_scheduler: clock-count reference model plus directed scenarios.
module tb_buzzer_scheduler;

    localparam int unsigned NOTE_W   = 8;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned MIN_HOLD = 3;
    localparam int unsigned GAP_LEN  = 2;
    localparam int PLAY_CLK = MIN_HOLD * TICK_DIV;
    localparam int GAP_CLK  = GAP_LEN * TICK_DIV;

    logic               clk = 1'b0;
    logic               rst;
    logic [NOTE_W-1:0]  key;
    logic [2:0]         req;
    logic [3*NOTE_W-1:0] song_notes;
    logic [2:0]         ack;
    logic [NOTE_W-1:0]  freq;
    logic               ring;
    logic [2:0]         owner;

    int n_total = 0;
    int n_pass  = 0;

    buzzer_scheduler #(
        .NOTE_W   (NOTE_W),
        .TICK_DIV (TICK_DIV),
        .MIN_HOLD (MIN_HOLD),
        .GAP_LEN  (GAP_LEN)
    ) dut (
        .iClk       (clk),
        .iReset     (rst),
        .iKey_Note  (key),
        .iSong_Req  (req),
        .iSong_Note (song_notes),
        .iSong_Ack  (ack),
        .oFreq_Data (freq),
        .oRing      (ring),
        .oOwner     (owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phases measured in clocks, songs picked by a modular scan.
    int          m_mode;   // 0 idle, 1 sounding, 2 gap
    int          m_n;
    int          m_last;
    logic [7:0]  m_freq;
    logic        m_ring;
    logic [2:0]  m_owner;
    logic [2:0]  m_ack;
    bit          m_valid = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_mode = 0; m_n = 0; m_last = 2;
                m_freq = 8'h00; m_ring = 1'b0; m_owner = 3'd0; m_ack = 3'b000;
                m_valid = 1'b1;
            end else if (m_valid) begin
                m_ack = 3'b000;
                case (m_mode)
                    0: begin
                        if (key != 8'h00) begin
                            m_mode = 1; m_n = 0;
                            m_owner = 3'd1; m_freq = key; m_ring = 1'b1;
                        end else if (req != 3'b000) begin
                            int k;
                            k = m_last;
                            for (int s = 1; s <= 3; s++) begin
                                if (req[(m_last + s) % 3]) begin
                                    k = (m_last + s) % 3;
                                    break;
                                end
                            end
                            m_ack[k] = 1'b1;
                            m_last   = k;
                            m_owner  = 3'(k + 2);
                            m_freq   = song_notes[k*8 +: 8];
                            m_ring   = (m_freq != 8'h00);
                            m_mode = 1; m_n = 0;
                        end
                    end
                    1: begin
                        m_n++;
                        if (m_n >= PLAY_CLK) begin
                            bit leave;
                            if (m_owner == 3'd1) leave = (key != m_freq);
                            else                 leave = (key != 8'h00) || (req != 3'b000);
                            if (leave) begin
                                m_mode = 2; m_n = 0; m_ring = 1'b0;
                            end
                        end
                    end
                    default: begin
                        m_n++;
                        if (m_n >= GAP_CLK) begin
                            m_mode = 0; m_n = 0;
                            m_owner = 3'd0; m_freq = 8'h00; m_ring = 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("cycle_outputs", {17'd0, ack, owner, ring, freq},
                      {17'd0, m_ack, m_owner, m_ring, m_freq});
                if (ack !== 3'b000) check("ack_onehot", $countones(ack), 1);
            end
        end
    end

    // Directed scenarios.
    initial begin
        int n;
        int g;
        int cnt;
        logic [2:0] seq [4];

        rst = 1'b1; key = 8'h00; req = 3'b000;
        song_notes = {8'h53, 8'h00, 8'h31};
        repeat (2) @(negedge clk);
        check("reset_outputs", {17'd0, ack, owner, ring, freq}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Keyboard note, released early: held for the full minimum, then the gap.
        key = 8'h15;
        @(negedge clk);
        check("s1_ring", ring, 1);
        check("s1_freq", freq, 8'h15);
        check("s1_owner", owner, 1);
        check("s1_noack", ack, 0);
        n = 0;
        while (ring === 1'b1 && n < 500) begin
            n++;
            if (n == 8) key = 8'h00;
            @(negedge clk);
        end
        check("s1_play_clocks", n, 12);
        g = 0;
        while (ring === 1'b0 && owner === 3'd1 && g < 500) begin
            g++;
            @(negedge clk);
        end
        check("s1_gap_clocks", g, 8);
        check("s1_idle_owner", owner, 0);

        // Keyboard beats a simultaneous song request; song1 (silent note) waits for the gap.
        @(negedge clk);
        key = 8'h20; req = 3'b010;
        @(negedge clk);
        check("s3_owner_key", owner, 1);
        check("s3_noack", ack, 0);
        check("s3_freq", freq, 8'h20);
        repeat (3) @(negedge clk);
        key = 8'h00;
        n = 0;
        while (ack === 3'b000 && n < 500) begin
            n++;
            @(negedge clk);
        end
        check("s3_ack_latency", n, 18);
        check("s3_ack_song1", ack, 3'b010);
        check("s3_owner_song1", owner, 3);
        check("s3_silent_note", ring, 0);
        req = 3'b000;
        repeat (15) @(negedge clk);
        check("s3_silent_sustain", {owner, ring}, {3'd3, 1'b0});

        // Reset mid-play silences immediately and restores song0-first order.
        rst = 1'b1;
        @(negedge clk);
        check("s5_reset_outputs", {17'd0, ack, owner, ring, freq}, 32'd0);
        rst = 1'b0;

        // All songs requesting continuously: rotation 0,1,2,0.
        req = 3'b111;
        cnt = 0; n = 0;
        while (cnt < 4 && n < 500) begin
            @(negedge clk);
            n++;
            if (ack !== 3'b000) begin
                seq[cnt] = ack;
                cnt++;
            end
        end
        req = 3'b000;
        check("s2_ack_count", cnt, 4);
        check("s2_ack0", seq[0], 3'b001);
        check("s2_ack1", seq[1], 3'b010);
        check("s2_ack2", seq[2], 3'b100);
        check("s2_ack3", seq[3], 3'b001);
        @(negedge clk);
        check("s2_ack_single_cycle", ack, 3'b000);

        // Song0 sustains with no competition, then yields to song2.
        repeat (12) @(negedge clk);
        n = 0;
        repeat (100) begin
            if (ring === 1'b1 && owner === 3'd2) n++;
            @(negedge clk);
        end
        check("s4_sustain_clocks", n, 100);
        req = 3'b101;
        @(negedge clk);
        req = 3'b100;
        check("s4_gap_entered", {owner, ring}, {3'd2, 1'b0});
        n = 0;
        while (ack === 3'b000 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("s4_ack_song2", ack, 3'b100);
        check("s4_freq_song2", freq, 8'h53);
        check("s4_owner_song2", owner, 4);
        req = 3'b000;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
